// File: rtl/reg_file_pkg.sv
// Shared constants for the architectural register file and its neighbours.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package reg_file_pkg;

  localparam int REG_NUM       = 32;
  localparam int REG_ID_BIT    = 5;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int ROB_WIDTH     = 1 << ROB_WIDTH_BIT;
  localparam int DATA_W        = 32;

  localparam logic [REG_ID_BIT-1:0] ZERO_REG = '0;

  // x0 is hardwired: never renamed, never written, always reads zero.
  function automatic logic is_zero_reg(input logic [REG_ID_BIT-1:0] id);
    return id == ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file with per-register busy bit and youngest-producer ROB tag.
// Latency: reads are combinational (0 cycles); issue/commit/flush visible the cycle after the edge.
// Backpressure: rdy_in low freezes all state; no handshake of its own.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (pause when low)
//   issue_valid/issue_rd/issue_rob_id      : Decoder renames a destination
//   rs1_id/rs2_id -> rsN_busy/value/dep     : operand lookup with commit bypass
//   commit_valid/rd/rob_id/value            : ROB retires the head entry
//   flush                                   : mispredict, drop all renames
module reg_file
  import reg_file_pkg::*;
#(
  parameter int REG_NUM       = reg_file_pkg::REG_NUM,
  parameter int ROB_WIDTH_BIT = reg_file_pkg::ROB_WIDTH_BIT
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,

  input  logic                     issue_valid,
  input  logic [REG_ID_BIT-1:0]    issue_rd,
  input  logic [ROB_WIDTH_BIT-1:0] issue_rob_id,

  input  logic [REG_ID_BIT-1:0]    rs1_id,
  input  logic [REG_ID_BIT-1:0]    rs2_id,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [DATA_W-1:0]        rs1_value,
  output logic [DATA_W-1:0]        rs2_value,
  output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
  output logic [ROB_WIDTH_BIT-1:0] rs2_dep,

  input  logic                     commit_valid,
  input  logic [REG_ID_BIT-1:0]    commit_rd,
  input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]        commit_value,

  input  logic                     flush
);

  logic [DATA_W-1:0]        value_q [REG_NUM];
  logic                     busy_q  [REG_NUM];
  logic [ROB_WIDTH_BIT-1:0] tag_q   [REG_NUM];

  // Commit/issue only take effect when not paused and not aimed at x0.
  logic commit_en;
  logic issue_en;

  assign commit_en = rdy_in && commit_valid && !is_zero_reg(commit_rd);
  assign issue_en  = rdy_in && issue_valid  && !is_zero_reg(issue_rd) && !flush;

  // ---------------------------------------------------------------------------
  // Read ports: two identical combinational lookups.
  // ---------------------------------------------------------------------------
  logic [REG_ID_BIT-1:0]    rd_id   [2];
  logic                     rd_busy [2];
  logic [DATA_W-1:0]        rd_val  [2];
  logic [ROB_WIDTH_BIT-1:0] rd_dep  [2];

  assign rd_id[0] = rs1_id;
  assign rd_id[1] = rs2_id;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    always_comb begin
      rd_busy[p] = busy_q[rd_id[p]];
      rd_val[p]  = value_q[rd_id[p]];
      rd_dep[p]  = tag_q[rd_id[p]];
      if (is_zero_reg(rd_id[p])) begin
        rd_busy[p] = 1'b0;
        rd_val[p]  = '0;
        rd_dep[p]  = '0;
      end else if (commit_en && commit_rd == rd_id[p] &&
                   busy_q[rd_id[p]] && tag_q[rd_id[p]] == commit_rob_id) begin
        // The producer retires this cycle: forward its result so the
        // consumer does not wait one more cycle for the write.
        rd_busy[p] = 1'b0;
        rd_val[p]  = commit_value;
      end
    end
  end

  assign rs1_busy  = rd_busy[0];
  assign rs1_value = rd_val[0];
  assign rs1_dep   = rd_dep[0];
  assign rs2_busy  = rd_busy[1];
  assign rs2_value = rd_val[1];
  assign rs2_dep   = rd_dep[1];

  // ---------------------------------------------------------------------------
  // State update. Statement order encodes priority: a later non-blocking
  // write to busy_q wins, so issue overrides a same-cycle commit release and
  // flush overrides everything on busy while the commit value still lands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (commit_en) begin
        value_q[commit_rd] <= commit_value;
        // Only the youngest producer may release; an older one retiring
        // leaves the newer rename in place.
        if (tag_q[commit_rd] == commit_rob_id)
          busy_q[commit_rd] <= 1'b0;
      end

      if (flush) begin
        for (int i = 0; i < REG_NUM; i++)
          busy_q[i] <= 1'b0;
      end else if (issue_en) begin
        busy_q[issue_rd] <= 1'b1;
        tag_q[issue_rd]  <= issue_rob_id;
      end
    end
  end

endmodule
